// File: rtl/bcd_seg_scan.sv
// Snapshot a 4-digit packed BCD value and scan it onto a multiplexed
// 7-segment display with optional leading-zero blanking and a non-BCD flag.
module bcd_seg_scan #(
  parameter int SCAN_DIV      = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        err
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [15:0]   snap;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          blank;
  logic          anyBad;
  logic [6:0]    segNext;
  logic [3:0]    anNext;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // A digit is blanked only when it and every more-significant digit are zero;
  // a non-BCD nibble is non-zero and therefore stops the chain.
  always_comb begin
    nib    = 4'h0;
    blank  = 1'b0;
    anyBad = 1'b0;
    case (idx)
      2'd0: nib = snap[3:0];
      2'd1: nib = snap[7:4];
      2'd2: nib = snap[11:8];
      2'd3: nib = snap[15:12];
      default: nib = 4'h0;
    endcase
    case (idx)
      2'd1: blank = (snap[15:4] == 12'h000);
      2'd2: blank = (snap[15:8] == 8'h00);
      2'd3: blank = (snap[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (snap[i*4 +: 4] > 4'd9) anyBad = 1'b1;
    end
    segNext = (BLANK_LEADING && blank) ? 7'h00 : decode(nib);
    anNext  = 4'b0001 << idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap <= 16'h0000;
      cnt  <= '0;
      idx  <= 2'd0;
      seg  <= 7'h00;
      an   <= 4'b0000;
      err  <= 1'b0;
    end else begin
      if (load) snap <= bcd;
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg <= segNext;
      an  <= anNext;
      err <= anyBad;
    end
  end

endmodule
